// File: rtl/restoring_div_16by8_if.sv
// Handshake and data bundle for the 2W/W restoring divider.
`timescale 1ns/1ps
interface restoring_div_16by8_if #(
    parameter int W = 8
);
    logic           start;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;
    logic           ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface

// File: rtl/restoring_div_16by8.sv
// Sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Optional macro DIV_OVF_DETECT_EN enables early quotient-overflow detection and the ovf flag.
`timescale 1ns/1ps
module restoring_div_16by8 #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    restoring_div_16by8_if.slave bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic          accept;
    logic          div_zero;
    logic          last_step;
    logic [CW-1:0] cnt;

    // R[W] never feeds the next step, so only R[W-1:0] is stored.
    logic [W-1:0] r_work;
    logic [W-1:0] lo_work;
    logic [W-1:0] div_reg;
    logic [W-2:0] q_work;

    logic [W:0]   t;
    logic         ge;
    logic [W-1:0] r_next;
    logic [W-1:0] q_next;

    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         dbz;
    logic         busy;
    logic         done;

`ifdef DIV_OVF_DETECT_EN
    logic hi_ovf;
    logic ovf;
    assign hi_ovf = !div_zero && (bus.dividend[2*W-1:W] >= bus.divisor);
`endif

    assign accept    = (state == IDLE) && bus.start;
    assign div_zero  = (bus.divisor == '0);
    assign last_step = (cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef DIV_OVF_DETECT_EN
                    state_next = (div_zero || hi_ovf) ? DONE : CALC;
`else
                    state_next = div_zero ? DONE : CALC;
`endif
                end
            end
            CALC: begin
                if (last_step) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        t      = {r_work, lo_work[W-1]};
        ge     = (t >= {1'b0, div_reg});
        r_next = ge ? (t[W-1:0] - div_reg) : t[W-1:0];
        q_next = {q_work, ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            r_work  <= bus.dividend[2*W-1:W];
            lo_work <= bus.dividend[W-1:0];
            div_reg <= bus.divisor;
            q_work  <= '0;
        end else if (state == CALC) begin
            r_work  <= r_next;
            lo_work <= {lo_work[W-2:0], 1'b0};
            q_work  <= q_next[W-2:0];
        end
    end

    // Results and flags hold from done until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
            ovf       <= 1'b0;
`endif
        end else if (accept) begin
            dbz <= 1'b0;
`ifdef DIV_OVF_DETECT_EN
            ovf <= 1'b0;
`endif
            if (div_zero) begin
                quotient  <= '1;
                remainder <= bus.dividend[W-1:0];
                dbz       <= 1'b1;
            end
`ifdef DIV_OVF_DETECT_EN
            else if (hi_ovf) begin
                quotient  <= '1;
                remainder <= '0;
                ovf       <= 1'b1;
            end
`endif
        end else if ((state == CALC) && last_step) begin
            quotient  <= q_next;
            remainder <= r_next;
        end
    end

    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dbz       = dbz;
`ifdef DIV_OVF_DETECT_EN
    assign bus.ovf       = ovf;
`else
    assign bus.ovf       = 1'b0;
`endif

endmodule
